// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 1:8 TDM receive demux.
// Optional parity slot is enabled by defining PARITY_CHECK_EN.
package tdm_pkg;

  localparam int unsigned N_LANES = 8;
  localparam int unsigned SEL_W   = 3;

  // S_PARITY is only reachable when PARITY_CHECK_EN is defined.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_LANES - 1);

endpackage

// File: rtl/tdm_out_hold.sv
// One-word valid/ready holding register; flags a dropped word when full.
module tdm_out_hold
  import tdm_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [N_LANES-1:0] i_data,
  input  logic               i_ready,
  output logic [N_LANES-1:0] o_data,
  output logic               o_valid,
  output logic               o_overrun
);

  logic [N_LANES-1:0] r_data;
  logic               r_valid;
  logic               r_overrun;

  // Load when free or draining this edge; otherwise drop and pulse overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        if (!r_valid || i_ready) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/tdm_demux_1_8.sv
// Receive side of the 8:1 TDM serial link: rebuilds 8 lane samples into a word.
// Define PARITY_CHECK_EN for a 9-slot frame with an even-parity slot.
module tdm_demux_1_8
  import tdm_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in,
  input  logic               i_in_valid,
  input  logic               i_frame_start,
  output logic [SEL_W-1:0]   o_sel,
  output logic [N_LANES-1:0] o_out,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_overrun,
  output logic               o_sync_err,
  output logic               o_parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned SHADOW_W = N_LANES;
`else
  // Lane 7 goes straight into the commit word, so it is never stored.
  localparam int unsigned SHADOW_W = N_LANES - 1;
`endif

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_sel, w_sel_nxt;
  logic [SHADOW_W-1:0]  r_shadow, w_shadow_nxt;
  logic                 r_sync_err, w_sync_err_nxt;
  logic                 w_commit;
  logic [N_LANES-1:0]   w_commit_word;
`ifdef PARITY_CHECK_EN
  logic                 r_parity_err, w_parity_err_nxt;
`endif

  // State, lane counter, shadow word and error pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_shadow   <= '0;
      r_sync_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_shadow   <= w_shadow_nxt;
      r_sync_err <= w_sync_err_nxt;
`ifdef PARITY_CHECK_EN
      r_parity_err <= w_parity_err_nxt;
`endif
    end
  end

  // Next-state, sample capture and commit request.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_shadow_nxt   = r_shadow;
    w_sync_err_nxt = 1'b0;
    w_commit       = 1'b0;
    w_commit_word  = '0;
`ifdef PARITY_CHECK_EN
    w_parity_err_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_in_valid && i_frame_start) begin
          w_shadow_nxt[0] = i_in;
          w_sel_nxt       = SEL_W'(1);
          w_state_nxt     = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_in_valid) begin
          if (i_frame_start) begin
            w_sync_err_nxt  = 1'b1;
            w_shadow_nxt[0] = i_in;
            w_sel_nxt       = SEL_W'(1);
          end else if (r_sel == LAST_LANE) begin
            w_sel_nxt = '0;
`ifdef PARITY_CHECK_EN
            w_shadow_nxt[N_LANES-1] = i_in;
            w_state_nxt             = S_PARITY;
`else
            w_commit      = 1'b1;
            w_commit_word = {i_in, r_shadow};
            w_state_nxt   = S_IDLE;
`endif
          end else begin
            for (int k = 0; k < SHADOW_W; k++) begin
              if (r_sel == SEL_W'(k)) w_shadow_nxt[k] = i_in;
            end
            w_sel_nxt = r_sel + SEL_W'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (i_in_valid) begin
          if (i_frame_start) begin
            w_sync_err_nxt  = 1'b1;
            w_shadow_nxt[0] = i_in;
            w_sel_nxt       = SEL_W'(1);
            w_state_nxt     = S_COLLECT;
          end else begin
            // Word is committed even when parity mismatches.
            w_commit         = 1'b1;
            w_commit_word    = r_shadow;
            w_parity_err_nxt = ^{r_shadow, i_in};
            w_state_nxt      = S_IDLE;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  tdm_out_hold u_hold (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_commit),
    .i_data    (w_commit_word),
    .i_ready   (i_out_ready),
    .o_data    (o_out),
    .o_valid   (o_out_valid),
    .o_overrun (o_overrun)
  );

  assign o_sel      = r_sel;
  assign o_sync_err = r_sync_err;
`ifdef PARITY_CHECK_EN
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Directed table-driven bench for tdm_demux_1_8 (honours PARITY_CHECK_EN).
module tb_tdm_demux_1_8;

  logic       clk = 1'b0;
  logic       rst, d, v, fs, rdy;
  logic [2:0] sel;
  logic [7:0] out;
  logic       ov, ovr, se, pe;

  int n_checks = 0;
  int n_errors = 0;
  int vec_no   = 0;

  typedef struct {
    logic       v;
    logic       fs;
    logic       d;
    logic       rdy;
    logic [2:0] sel;
    logic [7:0] out;
    logic       ov;
    logic       ovr;
    logic       se;
    logic       pe;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  tdm_demux_1_8 dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_in          (d),
    .i_in_valid    (v),
    .i_frame_start (fs),
    .o_sel         (sel),
    .o_out         (out),
    .o_out_valid   (ov),
    .i_out_ready   (rdy),
    .o_overrun     (ovr),
    .o_sync_err    (se),
    .o_parity_err  (pe)
  );

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic iv, input logic ifs, input logic id, input logic irdy,
                      input logic [2:0] esel, input logic [7:0] eout, input logic eov,
                      input logic eovr, input logic ese, input logic epe);
    vec_t t;
    t.v = iv; t.fs = ifs; t.d = id; t.rdy = irdy;
    t.sel = esel; t.out = eout; t.ov = eov; t.ovr = eovr; t.se = ese; t.pe = epe;
    tbl.push_back(t);
  endtask

  // Valid lane samples lo..hi of word w; frame_start on lane 0.
  task automatic lanes(input logic [7:0] w, input int lo, input int hi, input logic irdy,
                       input logic [7:0] eout, input logic eov);
    for (int k = lo; k <= hi; k++)
      push(1'b1, k == 0, w[k], irdy, 3'(k + 1), eout, eov, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      v = tbl[i].v; fs = tbl[i].fs; d = tbl[i].d; rdy = tbl[i].rdy;
      @(posedge clk);
      #1;
      check("sel",        vec_no, 8'(sel), 8'(tbl[i].sel));
      check("out",        vec_no, out,     tbl[i].out);
      check("out_valid",  vec_no, 8'(ov),  8'(tbl[i].ov));
      check("overrun",    vec_no, 8'(ovr), 8'(tbl[i].ovr));
      check("sync_err",   vec_no, 8'(se),  8'(tbl[i].se));
      check("parity_err", vec_no, 8'(pe),  8'(tbl[i].pe));
      vec_no++;
    end
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; fs = 1'b0; d = 1'b0; rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel",       -1, 8'(sel), 8'h00);
    check("rst_out",       -1, out,     8'h00);
    check("rst_out_valid", -1, 8'(ov),  8'h00);
    check("rst_pulses",    -1, 8'({ovr, se, pe}), 8'h00);
    rst = 1'b0;

`ifndef PARITY_CHECK_EN
    // Samples in IDLE without a qualified frame_start are ignored.
    push(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    // Frame AA, consumer ready: valid for one cycle.
    lanes(8'hAA, 0, 6, 1'b1, 8'h00, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    // Frame 93 with a 3-cycle gap after lane 4.
    lanes(8'h93, 0, 4, 1'b1, 8'hAA, 1'b0);
    repeat (3) push(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    lanes(8'h93, 5, 6, 1'b1, 8'hAA, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h93, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h93, 1'b0, 1'b0, 1'b0, 1'b0);
    // Back-to-back AA then 93 with consumer stalled: second frame overruns.
    lanes(8'hAA, 0, 6, 1'b0, 8'h93, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    lanes(8'h93, 0, 6, 1'b0, 8'hAA, 1'b1);
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    // frame_start at sel=4 restarts as lane 0 of frame 01.
    lanes(8'hAA, 0, 3, 1'b1, 8'hAA, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    lanes(8'h01, 1, 6, 1'b1, 8'hAA, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    // Hold AA ahead of the reset test.
    lanes(8'hAA, 0, 6, 1'b0, 8'h01, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    // Frame AA with odd parity bit 1: mismatch, still committed.
    lanes(8'hAA, 0, 7, 1'b1, 8'h00, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    // Frame AA with correct parity 0, held for the reset test.
    lanes(8'hAA, 0, 7, 1'b0, 8'hAA, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    // Partial frame up to sel=5 with a word held.
    lanes(8'h93, 0, 4, 1'b0, 8'hAA, 1'b1);
    run_table();

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel",       -2, 8'(sel), 8'h00);
    check("async_rst_out",       -2, out,     8'h00);
    check("async_rst_out_valid", -2, 8'(ov),  8'h00);
    @(posedge clk);
    #1;
    v = 1'b0; fs = 1'b0; d = 1'b0; rdy = 1'b1;
    rst = 1'b0;

    // Full frame after reset.
`ifndef PARITY_CHECK_EN
    lanes(8'h93, 0, 6, 1'b1, 8'h00, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h93, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    lanes(8'h93, 0, 7, 1'b1, 8'h00, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h93, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h93, 1'b0, 1'b0, 1'b0, 1'b0);
    run_table();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
